// File: rtl/imem_pkg.sv
// Shared constants and FSM state type for the instruction-memory responder.
// The IMEM_LOAD_PORT_EN macro (used by imem_responder) adds the program-load port.
package imem_pkg;

    localparam logic [31:0] NOP                 = 32'h00000013;
    localparam int          DEPTH_WORDS_DEFAULT = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/imem_array.sv
// Word storage for imem_responder: one synchronous write port, one combinational read port.
// Contents are not reset; every word powers up holding a NOP.
module imem_array
    import imem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEFAULT,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          wrEn_i,
    input  logic [AW-1:0] wrIdx_i,
    input  logic [31:0]   wrData_i,
    input  logic [AW-1:0] rdIdx_i,
    output logic [31:0]   rdData_o
);

    logic [31:0] mem [DEPTH_WORDS];

    initial begin
        for (int i = 0; i < DEPTH_WORDS; i++) begin
            mem[i] = NOP;
        end
    end

    always @(posedge clk) begin
        if (wrEn_i) begin
            mem[wrIdx_i] <= wrData_i;
        end
    end

    // The read is combinational so a same-cycle write is seen only after the edge.
    assign rdData_o = mem[rdIdx_i];

endmodule

// File: rtl/imem_responder.sv
// Single-outstanding instruction fetch responder with configurable latency.
// Defining IMEM_LOAD_PORT_EN adds the load_en/load_addr/load_data program-load port.
module imem_responder
    import imem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEFAULT,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_addr,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_err
`ifdef IMEM_LOAD_PORT_EN
    ,
    input  logic        load_en,
    input  logic [63:0] load_addr,
    input  logic [31:0] load_data
`endif
);

    localparam int          AW         = $clog2(DEPTH_WORDS);
    localparam logic [63:0] BYTE_LIMIT = 64'(DEPTH_WORDS) * 64'd4;
    localparam logic [1:0]  CNT_INIT   = 2'(LATENCY - 1);

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] respData_q, respData_d;
    logic        respErr_q, respErr_d;

    logic          accept;
    logic          reqErr;
    logic [31:0]   arrData;
    logic          wrEn;
    logic [AW-1:0] wrIdx;
    logic [31:0]   wrData;

    assign accept = req_valid && (state_q == IDLE);
    assign reqErr = (req_addr[1:0] != 2'b00) || (req_addr >= BYTE_LIMIT);

`ifdef IMEM_LOAD_PORT_EN
    // Misaligned or out-of-range loads never reach the array.
    assign wrEn   = load_en && (load_addr[1:0] == 2'b00) && (load_addr < BYTE_LIMIT);
    assign wrIdx  = load_addr[AW+1:2];
    assign wrData = load_data;
`else
    assign wrEn   = 1'b0;
    assign wrIdx  = '0;
    assign wrData = '0;
`endif

    imem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .wrEn_i  (wrEn),
        .wrIdx_i (wrIdx),
        .wrData_i(wrData),
        .rdIdx_i (req_addr[AW+1:2]),
        .rdData_o(arrData)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 2'd0;
            respData_q <= 32'd0;
            respErr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            respData_q <= respData_d;
            respErr_q  <= respErr_d;
        end
    end

    // The word is captured at accept time, so later loads cannot disturb it.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        respData_d = respData_q;
        respErr_d  = respErr_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    respErr_d  = reqErr;
                    respData_d = reqErr ? NOP : arrData;
                    cnt_d      = CNT_INIT;
                    state_d    = (LATENCY == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                if (cnt_q <= 2'd1) begin
                    cnt_d   = 2'd0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 2'd0;
            end
        endcase
    end

    always_comb begin
        req_ready  = (state_q == IDLE);
        resp_valid = (state_q == RESP);
        resp_data  = 32'd0;
        resp_err   = 1'b0;
        if (state_q == RESP) begin
            resp_data = respData_q;
            resp_err  = respErr_q;
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Randomized self-checking bench for imem_responder against a word-array reference model.
// Load-port scenarios are exercised only when IMEM_LOAD_PORT_EN is defined.
module tb_imem_responder;
    import imem_pkg::*;

    localparam int DEPTH = 256;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_err;
`ifdef IMEM_LOAD_PORT_EN
    logic        load_en;
    logic [63:0] load_addr;
    logic [31:0] load_data;
`endif

    int checkCount = 0;
    int errorCount = 0;

    logic [31:0] modelMem [DEPTH];

    imem_responder #(
        .DEPTH_WORDS(DEPTH),
        .LATENCY    (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_data (resp_data),
        .resp_err  (resp_err)
`ifdef IMEM_LOAD_PORT_EN
        ,
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic modelErr(input logic [63:0] a);
        return (a % 64'd4 != 64'd0) || (a >= 64'(DEPTH) * 64'd4);
    endfunction

    function automatic logic [31:0] modelData(input logic [63:0] a);
        if (modelErr(a)) return NOP;
        return modelMem[int'(a / 64'd4)];
    endfunction

    function automatic logic [63:0] randAddr();
        logic [63:0] a;
        case ($urandom_range(0, 3))
            0: a = 64'($urandom_range(0, DEPTH - 1)) * 64'd4;
            1: a = 64'($urandom_range(0, DEPTH * 4 - 1)) | 64'($urandom_range(1, 3));
            2: a = {32'($urandom), 32'($urandom)} | 64'h400;
            default: a = ($urandom_range(0, 1) == 0) ? 64'h3FC : 64'h400;
        endcase
        return a;
    endfunction

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

`ifdef IMEM_LOAD_PORT_EN
    task automatic modelLoad(input logic [63:0] a, input logic [31:0] d);
        if (!modelErr(a)) modelMem[int'(a / 64'd4)] = d;
    endtask

    task automatic loadWord(input logic [63:0] a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        stepCycle();
        load_en = 1'b0;
        modelLoad(a, d);
    endtask
`endif

    // One full fetch: accept, latency, optional stall with resp_ready low, then handshake.
    task automatic applyStimulus(input logic [63:0] addr, input int stall);
        logic [31:0] expData;
        logic        expErr;
        int          waited;
        expErr  = modelErr(addr);
        expData = modelData(addr);
        checkOutput("idle_req_ready", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_addr  = addr;
        stepCycle();
        req_valid = 1'b0;
`ifdef IMEM_LOAD_PORT_EN
        if (load_en) begin
            modelLoad(load_addr, load_data);
            load_en = 1'b0;
        end
`endif
        waited = 0;
        while (!resp_valid && waited < 8) begin
            checkOutput("busy_req_ready", 64'(req_ready), 64'd0);
            checkOutput("busy_resp_data", 64'(resp_data), 64'd0);
            stepCycle();
            waited++;
        end
        checkOutput("latency", 64'(waited + 1), 64'(LAT));
        if (!resp_valid) return;
        checkOutput("resp_data", 64'(resp_data), 64'(expData));
        checkOutput("resp_err", 64'(resp_err), 64'(expErr));
        for (int s = 0; s < stall; s++) begin
            stepCycle();
            checkOutput("stall_valid", 64'(resp_valid), 64'd1);
            checkOutput("stall_data", 64'(resp_data), 64'(expData));
            checkOutput("stall_req_ready", 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        stepCycle();
        resp_ready = 1'b0;
        checkOutput("post_valid", 64'(resp_valid), 64'd0);
        checkOutput("post_req_ready", 64'(req_ready), 64'd1);
        checkOutput("post_data", 64'(resp_data), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) modelMem[i] = NOP;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_addr   = 64'd0;
        resp_ready = 1'b0;
`ifdef IMEM_LOAD_PORT_EN
        load_en   = 1'b0;
        load_addr = 64'd0;
        load_data = 32'd0;
`endif
        stepCycle();
        stepCycle();
        checkOutput("rst_req_ready", 64'(req_ready), 64'd1);
        checkOutput("rst_resp_valid", 64'(resp_valid), 64'd0);
        checkOutput("rst_resp_data", 64'(resp_data), 64'd0);
        checkOutput("rst_resp_err", 64'(resp_err), 64'd0);
        rst = 1'b0;
        stepCycle();

`ifdef IMEM_LOAD_PORT_EN
        loadWord(64'h0, 32'h3c011001);
        applyStimulus(64'h0, 0);
        loadWord(64'h14, 32'h240a0001);
        load_en   = 1'b1;
        load_addr = 64'h14;
        load_data = 32'hdeadbeef;
        applyStimulus(64'h14, 0);
        applyStimulus(64'h14, 0);
        for (int i = 0; i < 24; i++) begin
            loadWord(randAddr(), $urandom);
        end
`else
        applyStimulus(64'h0, 0);
        applyStimulus(64'h3FC, 0);
`endif
        applyStimulus(64'h2, 0);
        applyStimulus(64'h400, 0);
        applyStimulus(64'h4, 3);

        for (int i = 0; i < 40; i++) begin
            applyStimulus(randAddr(), int'($urandom_range(0, 3)));
        end

        // Reset while a fetch is in flight must drop it entirely.
        req_valid = 1'b1;
        req_addr  = 64'h0;
        stepCycle();
        req_valid = 1'b0;
        checkOutput("busy_before_rst", 64'(req_ready), 64'd0);
        rst = 1'b1;
        #1;
        checkOutput("rst_busy_req_ready", 64'(req_ready), 64'd1);
        checkOutput("rst_busy_valid", 64'(resp_valid), 64'd0);
        stepCycle();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            stepCycle();
            checkOutput("after_rst_valid", 64'(resp_valid), 64'd0);
            checkOutput("after_rst_ready", 64'(req_ready), 64'd1);
        end
        applyStimulus(64'h0, 0);
        applyStimulus(64'h14, 1);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256: number of 32-bit instruction words stored.
REQ-002 SHALL have parameter LATENCY, default 2, legal 1..4: cycles from request accept to resp_valid.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid, input, 1: fetch side presents an address.
REQ-006 SHALL have port req_ready, output, 1: responder can accept a request.
REQ-007 SHALL have port req_addr, input, 64: byte address (the PC).
REQ-008 SHALL have port resp_valid, output, 1: response data valid.
REQ-009 SHALL have port resp_ready, input, 1: fetch side consumes the response.
REQ-010 SHALL have port resp_data, output, 32: fetched instruction word.
REQ-011 SHALL have port resp_err, output, 1: address misaligned or out of range.
REQ-012 SHALL have ports load_en (input, 1), load_addr (input, 64, byte address) and load_data (input, 32): program-load write port, present only per REQ-027.

Function
REQ-013 SHALL accept a request on any cycle where req_valid && req_ready.
REQ-014 SHALL implement FSM IDLE -> BUSY -> RESP -> IDLE; one request outstanding at a time.
REQ-015 SHALL assert req_ready only in IDLE.
REQ-016 IDLE: on accept, SHALL capture the word and error flag, load the latency counter with LATENCY-1, then go to BUSY, or directly to RESP when LATENCY=1.
REQ-017 BUSY: SHALL decrement the counter each cycle and enter RESP when it reaches 0; resp_valid rises exactly LATENCY cycles after the accept edge.
REQ-018 RESP: SHALL hold resp_valid, resp_data and resp_err stable until resp_ready=1, then return to IDLE on that edge.
REQ-019 SHALL index the array as req_addr[log2(DEPTH_WORDS)+1:2].
REQ-020 SHALL set resp_err=1 with resp_data=32'h00000013 (NOP) when req_addr[1:0]!=0 or req_addr>=DEPTH_WORDS*4, comparing all 64 bits.
REQ-021 SHALL read the array at accept time; later loads do not alter an in-flight response.
REQ-022 SHALL write load_data to word load_addr[..:2] on any cycle load_en=1, in any FSM state; out-of-range or misaligned loads are dropped silently.
REQ-023 When a load and an accepted request hit the same word in the same cycle, SHALL return the old data (read-before-write).
REQ-024 SHALL hold resp_data at 0 whenever resp_valid=0.

Reset
REQ-025 While rst=1: state=IDLE, req_ready=1, resp_valid=0, resp_data=0, resp_err=0, counter=0; an in-flight request is dropped and no response is produced.
REQ-026 SHALL NOT reset array contents; every word powers up (initial block) as 32'h00000013.

Configuration
REQ-027 Macro IMEM_LOAD_PORT_EN: when defined, load_en, load_addr and load_data exist and operate per REQ-022/023; when undefined, those ports are absent and the array is read-only, holding its initial contents.

Structure
REQ-028 Package imem_pkg SHALL hold the NOP constant 32'h00000013, the FSM state enum (IDLE, BUSY, RESP) and the DEPTH_WORDS default.
REQ-029 Storage SHALL be the sub-module imem_array: one synchronous write port and one read port; FSM, counter and error checks stay in imem_responder.

Verification
REQ-030 Load 32'h3c011001 at addr 0, request addr 0 with LATENCY=2, resp_ready=1 -> resp_valid 2 cycles after accept, resp_data=32'h3c011001, resp_err=0, req_ready=1 the cycle after.
REQ-031 Request addr 64'h2 -> resp_err=1, resp_data=32'h00000013; request addr 64'h400 with DEPTH_WORDS=256 -> resp_err=1.
REQ-032 Request addr 0x4, hold resp_ready=0 for 3 cycles -> resp_valid/resp_data stable, req_ready=0 throughout; IDLE is reached the edge resp_ready=1 is sampled.
REQ-033 Word 5 holds 32'h240a0001; in the same cycle, load 32'hdeadbeef to addr 0x14 and accept a request for 0x14 -> response 32'h240a0001; next request to 0x14 -> 32'hdeadbeef.
REQ-034 Assert rst during BUSY -> resp_valid never rises, req_ready=1 immediately, previously loaded contents still readable after reset.
REQ-035 Without IMEM_LOAD_PORT_EN, read addresses 0, 0x3FC -> 32'h00000013, resp_err=0.
